// File: rtl/rotate_pkg.sv
// Shared segment encodings for the rotating-square display.
package rotate_pkg;
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_UPPER = 8'h9C;
  localparam seg_t SEG_LOWER = 8'hA3;
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DP_OFF = 8'h80;
endpackage

// File: rtl/sseg_scan_n.sv
// Multiplexed seven-segment scanner: refresh counter, digit index and
// registered active-low an/digit outputs.
module sseg_scan_n
  import rotate_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  seg_t [NUM_DIGITS-1:0]       seg_i,
  output logic [NUM_DIGITS-1:0]       an_o,
  output seg_t                        digit_o
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  dig_q, dig_d;

  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (rcnt_q == R_LAST) begin
      rcnt_d = '0;
      idx_d  = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    end
    an_d         = '1;
    an_d[idx_q]  = 1'b0;
    // Decimal point is never lit regardless of the pattern fed in.
    dig_d        = seg_i[idx_q] | SEG_DP_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      dig_q  <= SEG_BLANK;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      dig_q  <= dig_d;
    end
  end

  assign an_o    = an_q;
  assign digit_o = dig_q;
endmodule

// File: rtl/rotate_square_n.sv
// Square that circles around a row of seven-segment digits.
// Optional macro ROTATE_STEP_EN adds a manual single-step input.
module rotate_square_n
  import rotate_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 10_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clockwise,
  input  logic [1:0]            speed,
`ifdef ROTATE_STEP_EN
  input  logic                  step,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            digit
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int PW = (NUM_DIGITS > 0) ? $clog2(2 * NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(2 * NUM_DIGITS - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic [TW-1:0] term;
  logic          tick, mv;
  seg_t [NUM_DIGITS-1:0] seg;

  // Terminal follows the live speed, so a faster setting with an already
  // larger count fires immediately instead of wrapping around.
  assign term = TW'(TICK_DIV >> speed) - 1'b1;
  assign tick = enable && (cnt_q >= term);

  always_comb begin
    cnt_d = cnt_q;
    p_d   = p_q;
    mv    = 1'b0;
    if (enable) begin
      if (tick) begin
        cnt_d = '0;
        mv    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef ROTATE_STEP_EN
    else if (step) begin
      mv = 1'b1;
    end
`endif
    if (mv) begin
      if (clockwise) p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
      else           p_d = (p_q == '0) ? P_LAST : p_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  // Upper half walks leftward-indexed digits N-1..0, lower half 0..N-1.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_pat
    localparam logic [PW-1:0] UP_P = PW'(NUM_DIGITS - 1 - d);
    localparam logic [PW-1:0] LO_P = PW'(NUM_DIGITS + d);
    assign seg[d] = (p_q == UP_P) ? SEG_UPPER :
                    (p_q == LO_P) ? SEG_LOWER : SEG_BLANK;
  end

  sseg_scan_n #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .seg_i  (seg),
    .an_o   (an),
    .digit_o(digit)
  );
endmodule
